// File: rtl/hex_text_writer_pkg.sv
// Shared screen geometry, ASCII constants and state encodings
// for the hex text writer.
package hex_text_writer_pkg;

  localparam int SCREEN_COLS = 80;
  localparam int SCREEN_ROWS = 30;

  localparam logic [6:0] ASCII_0 = 7'h30;
  localparam logic [6:0] ASCII_x = 7'h78;
  localparam logic [6:0] ASCII_A = 7'h41;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX0  = 3'd1,
    ST_PFX1  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_CLR   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/hex_text_writer_nibble.sv
// Combinational nibble to uppercase ASCII hex digit.
// 0-9 map to '0'-'9', A-F map to 'A'-'F'.
module hex_nibble_ascii
  import hex_text_writer_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_ascii
);

  // pick the digit or letter range
  always_comb begin
    if (i_nib < 4'd10) begin
      o_ascii = ASCII_0 + {3'b000, i_nib};
    end else begin
      o_ascii = ASCII_A + {3'b000, i_nib} - 7'd10;
    end
  end

endmodule

// File: rtl/hex_text_writer.sv
// Writes a 32-bit value as hex text into screen RAM, or
// fills the visible 80x30 screen with a clear character.
module hex_text_writer
  import hex_text_writer_pkg::*;
#(
  parameter bit         PREFIX   = 1'b1,
  parameter logic [6:0] CLR_CHAR = 7'h20
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_clear,
  input  logic [31:0] i_value,
  input  logic [4:0]  i_row,
  input  logic [6:0]  i_col,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_wr_en,
  output logic [11:0] o_wr_addr,
  output logic [6:0]  o_wr_data
);

  localparam logic [2:0] DIG_OFS  = PREFIX ? 3'd2 : 3'd0;
  localparam logic [3:0] LAST_K   = PREFIX ? 4'd9 : 4'd7;
  localparam logic [6:0] LAST_COL = 7'(SCREEN_COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(SCREEN_ROWS - 1);

  state_t      r_state;
  logic [31:0] r_value;
  logic [4:0]  r_row;
  logic [6:0]  r_col;
  logic [3:0]  r_k;
  logic [4:0]  r_crow;
  logic [6:0]  r_ccol;
  logic        r_busy;
  logic        r_done;
  logic        r_wr_en;
  logic [11:0] r_wr_addr;
  logic [6:0]  r_wr_data;

  state_t      w_state_n;
  logic [31:0] w_value_n;
  logic [4:0]  w_row_n;
  logic [6:0]  w_col_n;
  logic [3:0]  w_k_n;
  logic [4:0]  w_crow_n;
  logic [6:0]  w_ccol_n;
  logic [2:0]  w_dig;
  logic [2:0]  w_nsel;
  logic [3:0]  w_nib;
  logic [6:0]  w_hex;
  logic        w_busy_n;
  logic        w_done_n;
  logic        w_wr_en_n;
  logic [11:0] w_wr_addr_n;
  logic [6:0]  w_wr_data_n;

  // nibble for the character about to be written, MSB first
  assign w_dig  = w_k_n[2:0] - DIG_OFS;
  assign w_nsel = 3'd7 - w_dig;
  assign w_nib  = w_value_n[{w_nsel, 2'b00} +: 4];

  hex_nibble_ascii u_nib (
    .i_nib   (w_nib),
    .o_ascii (w_hex)
  );

  // next state, operand latching and write counters
  always_comb begin
    w_state_n = r_state;
    w_value_n = r_value;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_k_n     = r_k;
    w_crow_n  = r_crow;
    w_ccol_n  = r_ccol;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_n = ST_IDLE;
        if (i_clear) begin
          w_state_n = ST_CLR;
          w_crow_n  = '0;
          w_ccol_n  = '0;
        end else if (i_start) begin
          w_state_n = PREFIX ? ST_PFX0 : ST_DIGIT;
          w_value_n = i_value;
          w_row_n   = i_row;
          w_col_n   = i_col;
          w_k_n     = '0;
        end
      end
      ST_PFX0: begin
        w_state_n = ST_PFX1;
        w_k_n     = r_k + 4'd1;
      end
      ST_PFX1: begin
        w_state_n = ST_DIGIT;
        w_k_n     = r_k + 4'd1;
      end
      ST_DIGIT: begin
        if (r_k == LAST_K) begin
          w_state_n = ST_DONE;
        end else begin
          w_k_n = r_k + 4'd1;
        end
      end
      ST_CLR: begin
        if (r_ccol == LAST_COL) begin
          w_ccol_n = '0;
          if (r_crow == LAST_ROW) begin
            w_state_n = ST_DONE;
          end else begin
            w_crow_n = r_crow + 5'd1;
          end
        end else begin
          w_ccol_n = r_ccol + 7'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // outputs for the coming cycle, decoded from the next state
  always_comb begin
    w_busy_n    = 1'b0;
    w_done_n    = 1'b0;
    w_wr_en_n   = 1'b0;
    w_wr_addr_n = {w_row_n, w_col_n + {3'b000, w_k_n}};
    w_wr_data_n = w_hex;
    unique case (w_state_n)
      ST_PFX0: begin
        w_busy_n    = 1'b1;
        w_wr_en_n   = 1'b1;
        w_wr_data_n = ASCII_0;
      end
      ST_PFX1: begin
        w_busy_n    = 1'b1;
        w_wr_en_n   = 1'b1;
        w_wr_data_n = ASCII_x;
      end
      ST_DIGIT: begin
        w_busy_n  = 1'b1;
        w_wr_en_n = 1'b1;
      end
      ST_CLR: begin
        w_busy_n    = 1'b1;
        w_wr_en_n   = 1'b1;
        w_wr_addr_n = {w_crow_n, w_ccol_n};
        w_wr_data_n = CLR_CHAR;
      end
      ST_DONE: w_done_n = 1'b1;
      default: w_done_n = 1'b0;
    endcase
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_value   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_k       <= '0;
      r_crow    <= '0;
      r_ccol    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_n;
      r_value   <= w_value_n;
      r_row     <= w_row_n;
      r_col     <= w_col_n;
      r_k       <= w_k_n;
      r_crow    <= w_crow_n;
      r_ccol    <= w_ccol_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_wr_en   <= w_wr_en_n;
      r_wr_addr <= w_wr_addr_n;
      r_wr_data <= w_wr_data_n;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_hex_text_writer.sv
// Scoreboard bench for hex_text_writer, PREFIX=1 and PREFIX=0
// instances driven in parallel from one randomized stimulus stream.
module tb_hex_text_writer;

  typedef struct {
    bit         fin;
    logic [11:0] addr;
    logic [6:0]  data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [31:0] value;
  logic [4:0]  row;
  logic [6:0]  col;

  logic        busy[2];
  logic        done[2];
  logic        wr_en[2];
  logic [11:0] wr_addr[2];
  logic [6:0]  wr_data[2];

  item_t q[2][$];
  int    left[2];
  bit    rst_chk[2];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  hex_text_writer #(.PREFIX(1'b1), .CLR_CHAR(7'h20)) u_p1 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_clear(clear),
    .i_value(value), .i_row(row), .i_col(col),
    .o_busy(busy[0]), .o_done(done[0]), .o_wr_en(wr_en[0]),
    .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0])
  );

  hex_text_writer #(.PREFIX(1'b0), .CLR_CHAR(7'h20)) u_p0 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_clear(clear),
    .i_value(value), .i_row(row), .i_col(col),
    .o_busy(busy[1]), .o_done(done[1]), .o_wr_en(wr_en[1]),
    .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1])
  );

  function automatic logic [6:0] hexch(int d);
    return (d < 10) ? 7'(48 + d) : 7'(55 + d);
  endfunction

  task automatic push_w(int g, int r, int c, logic [6:0] ch);
    item_t it;
    it.fin  = 1'b0;
    it.addr = 12'(r * 128 + (c % 128));
    it.data = ch;
    q[g].push_back(it);
  endtask

  task automatic push_done(int g);
    item_t it;
    it.fin  = 1'b1;
    it.addr = '0;
    it.data = '0;
    q[g].push_back(it);
  endtask

  // reference model: what each instance does at this clock edge
  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      rst_chk[g] = 1'b0;
      if (rst) begin
        q[g].delete();
        left[g]    = 0;
        rst_chk[g] = 1'b1;
      end else if (left[g] == 0 && (clear || start)) begin
        if (clear) begin
          for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
              push_w(g, r, c, 7'h20);
          left[g] = 2400;
        end else begin
          int k = 0;
          if (g == 0) begin
            push_w(g, row, col, 7'h30);
            push_w(g, row, col + 1, 7'h78);
            k = 2;
          end
          for (int i = 0; i < 8; i++) begin
            int d = int'((value >> (28 - 4 * i)) & 32'hF);
            push_w(g, row, col + k, hexch(d));
            k++;
          end
          left[g] = k;
        end
        push_done(g);
      end else if (left[g] > 0) begin
        left[g]--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // monitor: every cycle the output must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        bit    e_en, e_done, e_busy, ok;
        item_t it;
        it.fin = 1'b0; it.addr = '0; it.data = '0;
        e_en = 1'b0; e_done = 1'b0;
        e_busy = (left[g] > 0);
        if (q[g].size() > 0) begin
          it = q[g].pop_front();
          e_en   = !it.fin;
          e_done = it.fin;
        end
        ok = (wr_en[g] === e_en) && (done[g] === e_done) &&
             (busy[g] === e_busy);
        if (e_en)
          ok = ok && (wr_addr[g] === it.addr) && (wr_data[g] === it.data);
        if (rst_chk[g])
          ok = ok && (wr_addr[g] === 12'd0) && (wr_data[g] === 7'd0);
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL %s dut%0d t=%0t: got en=%0b done=%0b busy=%0b addr=%0d data=%h, want en=%0b done=%0b busy=%0b addr=%0d data=%h",
                   rst_chk[g] ? "reset" : (e_en ? "write" : (e_done ? "done" : "idle")),
                   g, $time, wr_en[g], done[g], busy[g], wr_addr[g], wr_data[g],
                   e_en, e_done, e_busy, it.addr, it.data);
        end
      end
    end
  end

  task automatic wait_idle(bit noise);
    int n = 0;
    while ((left[0] > 0 || left[1] > 0) && n < 5000) begin
      if (noise) begin
        value = $urandom;
        row   = 5'($urandom_range(0, 31));
        col   = 7'($urandom_range(0, 127));
        start = 1'($urandom_range(0, 1));
      end
      step();
      n++;
    end
    start = 1'b0;
    clear = 1'b0;
    if (n >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", n);
    end
    step();
  endtask

  task automatic req_start(logic [31:0] v, int r, int c);
    value = v;
    row   = 5'(r);
    col   = 7'(c);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    value = '0; row = '0; col = '0;
    left[0] = 0; left[1] = 0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;

    req_start(32'h1234ABCF, 3, 10);
    wait_idle(1'b0);
    req_start(32'h000000F0, 0, 124);
    wait_idle(1'b0);

    repeat (25) begin
      req_start($urandom, $urandom_range(0, 31), $urandom_range(0, 127));
      wait_idle(1'b1);
    end

    value = 32'hDEADBEEF; row = 5'd7; col = 7'd3;
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    repeat (20) begin
      step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_idle(1'b0);

    req_start(32'hCAFE0123, 31, 120);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req_start(32'h89ABCDEF, 29, 70);
    wait_idle(1'b0);

    value = 32'h0F1E2D3C; row = 5'd12; col = 7'd40;
    start = 1'b1;
    repeat (40) begin
      step();
      value = $urandom;
    end
    start = 1'b0;
    wait_idle(1'b0);

    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      n_cmp++;
      if (q[g].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut%0d: %0d items left, want 0", g, q[g].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
